// File: rtl/uart_port_master_pkg.sv
// Shared definitions for the CoreUART parallel-port master: FSM encoding,
// rx_status bit positions and round-robin tags.
package uart_port_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int STAT_PAR = 0;
    localparam int STAT_FRM = 1;
    localparam int STAT_OVF = 2;

    localparam logic SERVED_TX = 1'b1;
    localparam logic SERVED_RX = 1'b0;

endpackage

// File: rtl/uart_err_counter.sv
// Saturating error event counter; clear wins over increment in the same cycle.
module uart_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/uart_port_master.sv
// Streams bytes into a CoreUART via its CSN/WEN/OEN port and drains received
// bytes (with error flags) into a valid/ready RX stream.
module uart_port_master
    import uart_port_master_pkg::*;
#(
    parameter int HOLDOFF = 3,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic [2:0]       rx_status,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] parity_cnt,
    output logic [CNT_W-1:0] framing_cnt,
    output logic [CNT_W-1:0] overflow_cnt,
    output logic             CSN,
    output logic             WEN,
    output logic             OEN,
    output logic [7:0]       DATA_IN,
    input  logic [7:0]       DATA_OUT,
    input  logic             TXRDY,
    input  logic             RXRDY,
    input  logic             PARITY_ERR,
    input  logic             FRAMING_ERR,
    input  logic             OVERFLOW,
    output logic [1:0]       dbg_state
);

    // Both streams use valid/ready: a transfer happens on a rising CLK edge
    // where valid and ready are both 1; valid holds its payload until then.

    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       last_q, last_d;
    logic       csn_q, csn_d;
    logic       wen_q, wen_d;
    logic       oen_q, oen_d;
    logic [7:0] din_q, din_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [2:0] rx_status_q, rx_status_d;
    logic       rx_valid_q, rx_valid_d;
    logic       wr_req;
    logic       rd_req;
    logic       in_read;

    assign wr_req  = tx_valid & TXRDY;
    assign rd_req  = RXRDY & ~rx_valid_q;
    assign in_read = (state_q == ST_READ);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        last_d      = last_q;
        csn_d       = 1'b1;
        wen_d       = 1'b1;
        oen_d       = 1'b1;
        din_d       = din_q;
        rx_data_d   = rx_data_q;
        rx_status_d = rx_status_q;
        rx_valid_d  = rx_valid_q;
        tx_ready    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Round-robin: on contention serve whichever side did not go last.
                if (wr_req && (!rd_req || (last_q == SERVED_RX))) begin
                    tx_ready = 1'b1;
                    din_d    = tx_data;
                    csn_d    = 1'b0;
                    wen_d    = 1'b0;
                    state_d  = ST_WRITE;
                end else if (rd_req) begin
                    csn_d   = 1'b0;
                    oen_d   = 1'b0;
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                last_d  = SERVED_TX;
                hold_d  = '0;
                state_d = ST_HOLD;
            end
            ST_READ: begin
                rx_data_d             = DATA_OUT;
                rx_status_d[STAT_PAR] = PARITY_ERR;
                rx_status_d[STAT_FRM] = FRAMING_ERR;
                rx_status_d[STAT_OVF] = OVERFLOW;
                rx_valid_d            = 1'b1;
                last_d                = SERVED_RX;
                hold_d                = '0;
                state_d               = ST_HOLD;
            end
            ST_HOLD: begin
                // UART ready flags are stale right after an access; wait them out.
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            last_q      <= SERVED_RX;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            din_q       <= '0;
            rx_data_q   <= '0;
            rx_status_q <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            din_q       <= din_d;
            rx_data_q   <= rx_data_d;
            rx_status_q <= rx_status_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    uart_err_counter #(.CNT_W(CNT_W)) u_par_cnt (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clear_i (cnt_clear),
        .inc_i   (in_read & PARITY_ERR),
        .count_o (parity_cnt)
    );

    uart_err_counter #(.CNT_W(CNT_W)) u_frm_cnt (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clear_i (cnt_clear),
        .inc_i   (in_read & FRAMING_ERR),
        .count_o (framing_cnt)
    );

    uart_err_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clear_i (cnt_clear),
        .inc_i   (in_read & OVERFLOW),
        .count_o (overflow_cnt)
    );

    assign CSN       = csn_q;
    assign WEN       = wen_q;
    assign OEN       = oen_q;
    assign DATA_IN   = din_q;
    assign rx_data   = rx_data_q;
    assign rx_status = rx_status_q;
    assign rx_valid  = rx_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_port_master.sv
// Directed bench for uart_port_master: table-driven reads/writes plus
// hand-written sequences for arbitration, saturation and reset abort.
module tb_uart_port_master;
  import uart_port_master_pkg::*;

  localparam int HOLDOFF = 3;
  localparam int CNT_W   = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic [2:0]       rx_status;
  logic             rx_valid;
  logic             rx_ready;
  logic             cnt_clear;
  logic [CNT_W-1:0] parity_cnt;
  logic [CNT_W-1:0] framing_cnt;
  logic [CNT_W-1:0] overflow_cnt;
  logic             CSN, WEN, OEN;
  logic [7:0]       DATA_IN;
  logic [7:0]       DATA_OUT;
  logic             TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW;
  logic [1:0]       dbg_state;

  uart_port_master #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_status(rx_status), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cnt_clear(cnt_clear), .parity_cnt(parity_cnt), .framing_cnt(framing_cnt),
    .overflow_cnt(overflow_cnt), .CSN(CSN), .WEN(WEN), .OEN(OEN), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR),
    .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [7:0] dout;
    logic       par;
    logic       frm;
    logic       ovf;
    logic [7:0] exp_data;
    logic [2:0] exp_status;
  } rd_vec_t;

  rd_vec_t    rd_tab[4];
  logic [7:0] wr_tab[2];
  logic [7:0] exp_q[$];
  int         wen_cyc[$];
  logic [7:0] wen_data[$];
  int         oen_cyc[$];
  logic       acc_kind[$];
  int         viol = 0;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         exp_par, exp_frm, exp_ovf;
  int         hs0, hs1, t0, first_v, bad, dummy;
  logic       seen, found;

  always @(negedge CLK) begin
    if (!WEN) begin
      wen_cyc.push_back(cyc);
      wen_data.push_back(DATA_IN);
      acc_kind.push_back(1'b1);
    end
    if (!OEN) begin
      oen_cyc.push_back(cyc);
      acc_kind.push_back(1'b0);
    end
    if (!WEN && !OEN) viol++;
    if (tx_ready && (!TXRDY || dbg_state != ST_IDLE)) viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; cnt_clear = 1'b0;
    DATA_OUT = 8'h00; TXRDY = 1'b0; RXRDY = 1'b0;
    PARITY_ERR = 1'b0; FRAMING_ERR = 1'b0; OVERFLOW = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    wen_cyc.delete(); wen_data.delete(); oen_cyc.delete(); acc_kind.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int hs_cyc);
    logic ok;
    ok = 1'b0;
    hs_cyc = -1;
    tx_data = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge CLK);
      if (tx_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
      end
    end
    check("tx_accept", {31'd0, ok}, 32'd1);
    @(posedge CLK);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_oen_and_drop(input string name);
    logic got;
    got = 1'b0;
    RXRDY = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge CLK);
      if (!OEN) got = 1'b1;
    end
    RXRDY = 1'b0;
    check(name, {31'd0, got}, 32'd1);
  endtask

  task automatic read_one(input rd_vec_t v, input int idx);
    logic got;
    DATA_OUT = v.dout; PARITY_ERR = v.par; FRAMING_ERR = v.frm; OVERFLOW = v.ovf;
    wait_oen_and_drop($sformatf("rd%0d_oen", idx));
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      if (rx_valid) got = 1'b1;
    end
    check($sformatf("rd%0d_valid", idx), {31'd0, got}, 32'd1);
    check($sformatf("rd%0d_data", idx), {24'd0, rx_data}, {24'd0, v.exp_data});
    check($sformatf("rd%0d_status", idx), {29'd0, rx_status}, {29'd0, v.exp_status});
    exp_par += int'(v.exp_status[0]);
    exp_frm += int'(v.exp_status[1]);
    exp_ovf += int'(v.exp_status[2]);
    rx_ready = 1'b1;
    @(posedge CLK);
    #1;
    rx_ready = 1'b0;
    check($sformatf("rd%0d_par_cnt", idx), {24'd0, parity_cnt}, exp_par);
    check($sformatf("rd%0d_frm_cnt", idx), {24'd0, framing_cnt}, exp_frm);
    check($sformatf("rd%0d_ovf_cnt", idx), {24'd0, overflow_cnt}, exp_ovf);
    PARITY_ERR = 1'b0; FRAMING_ERR = 1'b0; OVERFLOW = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    wr_tab[0] = 8'h55;
    wr_tab[1] = 8'hA3;
    rd_tab[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};
    rd_tab[1] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 3'b010};
    rd_tab[2] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 3'b111};
    rd_tab[3] = '{8'h7E, 1'b0, 1'b0, 1'b1, 8'h7E, 3'b100};

    // Reset values
    do_reset();
    check("rst_csn", {31'd0, CSN}, 32'd1);
    check("rst_wen", {31'd0, WEN}, 32'd1);
    check("rst_oen", {31'd0, OEN}, 32'd1);
    check("rst_data_in", {24'd0, DATA_IN}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_status", {29'd0, rx_status}, 32'd0);
    check("rst_counters", {8'd0, parity_cnt, framing_cnt, overflow_cnt}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // Back-to-back writes 0x55, 0xA3
    TXRDY = 1'b1;
    exp_q.push_back(wr_tab[0]);
    send_byte(wr_tab[0], hs0);
    exp_q.push_back(wr_tab[1]);
    send_byte(wr_tab[1], hs1);
    wait_cycles(10);
    check("wr_pulse_count", wen_cyc.size(), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (exp_q.size() > 0 && wen_data.size() > i)
        check($sformatf("wr%0d_data_in", i), {24'd0, wen_data[i]}, {24'd0, exp_q.pop_front()});
    end
    check("wr_latency", (wen_cyc.size() > 0) ? wen_cyc[0] : -1, hs0 + 1);
    check("wr_spacing", (wen_cyc.size() > 1) ? wen_cyc[1] - wen_cyc[0] : -1, 2 + HOLDOFF);

    // Single read with parity error under backpressure
    do_reset();
    DATA_OUT = 8'h3C; PARITY_ERR = 1'b1; RXRDY = 1'b1;
    t0 = cyc;
    first_v = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (rx_valid && first_v < 0) first_v = cyc;
    end
    wait_cycles(15);
    check("bp_read_count", oen_cyc.size(), 32'd1);
    check("bp_oen_latency", (oen_cyc.size() > 0) ? oen_cyc[0] : -1, t0 + 1);
    check("bp_rx_valid_latency", first_v, t0 + 2);
    check("bp_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("bp_rx_data", {24'd0, rx_data}, 32'h3C);
    check("bp_rx_status", {29'd0, rx_status}, 32'h1);
    check("bp_parity_cnt", {24'd0, parity_cnt}, 32'd1);
    DATA_OUT = 8'hC3; PARITY_ERR = 1'b0;
    rx_ready = 1'b1;
    @(posedge CLK);
    #1;
    rx_ready = 1'b0;
    wait_cycles(10);
    RXRDY = 1'b0;
    check("bp_second_read", oen_cyc.size(), 32'd2);
    check("bp_rx_data2", {24'd0, rx_data}, 32'hC3);
    check("bp_rx_status2", {29'd0, rx_status}, 32'h0);
    check("bp_parity_cnt2", {24'd0, parity_cnt}, 32'd1);

    // Table-driven reads
    do_reset();
    exp_par = 0; exp_frm = 0; exp_ovf = 0;
    for (int i = 0; i < 4; i++) begin
      read_one(rd_tab[i], i);
      wait_cycles(6);
    end

    // Continuous contention alternates, starting with a write
    do_reset();
    TXRDY = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; RXRDY = 1'b1; rx_ready = 1'b1;
    wait_cycles(40);
    tx_valid = 1'b0; RXRDY = 1'b0;
    wait_cycles(10);
    check("rr_access_count_ge6", {31'd0, acc_kind.size() >= 6}, 32'd1);
    for (int i = 0; i < 6 && i < acc_kind.size(); i++)
      check($sformatf("rr_access%0d_is_write", i), {31'd0, acc_kind[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);

    // TXRDY low blocks writes
    do_reset();
    TXRDY = 1'b0; tx_valid = 1'b1; tx_data = 8'hE7;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (tx_ready || !CSN) bad++;
    end
    check("txrdy_low_idle", bad, 32'd0);
    @(posedge CLK);
    #1;
    TXRDY = 1'b1;
    @(negedge CLK);
    hs0 = cyc;
    check("txrdy_high_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge CLK);
    #1;
    tx_valid = 1'b0;
    wait_cycles(5);
    check("txrdy_write_count", wen_cyc.size(), 32'd1);
    check("txrdy_write_latency", (wen_cyc.size() > 0) ? wen_cyc[0] : -1, hs0 + 1);
    check("txrdy_write_data", (wen_data.size() > 0) ? {24'd0, wen_data[0]} : 32'hFFFF, 32'hE7);

    // Framing counter saturation, then clear racing an error read
    do_reset();
    FRAMING_ERR = 1'b1; RXRDY = 1'b1; rx_ready = 1'b1;
    for (int k = 0; k < 4000 && oen_cyc.size() < 300; k++) wait_cycles(1);
    RXRDY = 1'b0;
    check("sat_reads_done", {31'd0, oen_cyc.size() >= 300}, 32'd1);
    wait_cycles(10);
    check("sat_framing_cnt", {24'd0, framing_cnt}, 32'd255);
    check("sat_parity_cnt", {24'd0, parity_cnt}, 32'd0);
    wait_oen_and_drop("clr_oen");
    cnt_clear = 1'b1;
    @(posedge CLK);
    #1;
    cnt_clear = 1'b0;
    check("clr_framing_cnt", {24'd0, framing_cnt}, 32'd0);
    wait_cycles(2);
    wait_oen_and_drop("post_clr_oen");
    wait_cycles(3);
    check("post_clr_framing_cnt", {24'd0, framing_cnt}, 32'd1);
    FRAMING_ERR = 1'b0; rx_ready = 1'b0;

    // Reset during HOLD after a write
    do_reset();
    DATA_OUT = 8'h99; OVERFLOW = 1'b1;
    wait_oen_and_drop("abort_pre_oen");
    wait_cycles(6);
    OVERFLOW = 1'b0;
    check("abort_pre_ovf_cnt", {24'd0, overflow_cnt}, 32'd1);
    check("abort_pre_rx_valid", {31'd0, rx_valid}, 32'd1);
    TXRDY = 1'b1; tx_valid = 1'b1; tx_data = 8'h42;
    seen = 1'b0; found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge CLK);
      if (!WEN) seen = 1'b1;
      else if (seen && dbg_state == ST_HOLD) found = 1'b1;
    end
    check("abort_reached_hold", {31'd0, found}, 32'd1);
    RESET = 1'b1; tx_valid = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_strobes", {29'd0, CSN, WEN, OEN}, 32'h7);
    check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("abort_counters", {8'd0, parity_cnt, framing_cnt, overflow_cnt}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    RESET = 1'b0;
    wait_cycles(2);

    check("protocol_invariants", viol, 32'd0);
    dummy = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
